// File: rtl/div_pkg.sv
// div_pkg: shared FSM states and sizing helper for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int data_w);
    return $clog2(2 * data_w);
  endfunction
endpackage

// File: rtl/seq_div_if.sv
// seq_div_if: pulse-valid request/result bundle for seq_div
interface seq_div_if #(parameter int DATA_W = 8);
  logic                  vld_in;
  logic [2*DATA_W-1:0]   N;
  logic [DATA_W-1:0]     D;
  logic                  busy;
  logic                  vld_out;
  logic [2*DATA_W-1:0]   quot_out;
  logic [DATA_W-1:0]     rem_out;
  logic                  div_zero;
  modport master(output vld_in, N, D, input busy, vld_out, quot_out, rem_out, div_zero);
  modport slave(input vld_in, N, D, output busy, vld_out, quot_out, rem_out, div_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step #(parameter int DATA_W = 8) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_div,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_q
);
  logic [DATA_W:0] w_trial;
  assign w_trial = {i_rem, i_bit};
  assign o_q     = w_trial >= {1'b0, i_div};
  // the subtracted value always fits back into DATA_W bits when the trial succeeds
  assign o_rem   = o_q ? DATA_W'(w_trial - {1'b0, i_div}) : w_trial[DATA_W-1:0];
endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, 2*DATA_W-bit numerator by DATA_W-bit divisor
module seq_div import div_pkg::*; #(parameter int DATA_W = 8) (
  input logic       clk,
  input logic       rst_n,
  seq_div_if.slave  bus
);
  localparam int CW = cnt_w(DATA_W);
  state_t              r_state;
  logic [2*DATA_W-1:0] r_num, r_quot;
  logic [DATA_W-1:0]   r_div, r_rem, r_rem_out, w_rem;
  logic [CW-1:0]       r_cnt;
  logic                r_busy, r_vld, r_dz, w_q, w_dz, w_last;
  div_step #(.DATA_W(DATA_W)) u_step (
    .i_rem(r_rem), .i_bit(r_num[2*DATA_W-1]), .i_div(r_div), .o_rem(w_rem), .o_q(w_q)
  );
  assign w_dz   = r_div == '0;
  assign w_last = r_cnt == CW'(2*DATA_W-1);
  // numerator register doubles as the quotient shift register: MSB out, quotient bit in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_vld     <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (r_state == S_RUN) begin
        r_num <= {r_num[2*DATA_W-2:0], w_q};
        r_rem <= w_rem;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_state   <= S_DONE;
          r_busy    <= 1'b0;
          r_vld     <= 1'b1;
          r_quot    <= w_dz ? '1 : {r_num[2*DATA_W-2:0], w_q};
          r_rem_out <= w_dz ? '0 : w_rem;
          r_dz      <= w_dz;
        end
      end else if (bus.vld_in) begin
        r_state <= S_RUN;
        r_num   <= bus.N;
        r_div   <= bus.D;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
  assign bus.busy     = r_busy;
  assign bus.vld_out  = r_vld;
  assign bus.quot_out = r_quot;
  assign bus.rem_out  = r_rem_out;
  assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div and standalone div_step
module tb_seq_div;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seq_div_if #(.DATA_W(W)) bus();
  seq_div #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [W-1:0] s_rem, s_div, s_orem;
  logic         s_bit, s_q;
  div_step #(.DATA_W(W)) stp (.i_rem(s_rem), .i_bit(s_bit), .i_div(s_div), .o_rem(s_orem), .o_q(s_q));
  typedef struct {
    logic [2*W-1:0] n;
    logic [W-1:0]   d;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dz;
    int             due;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [3*W:0] hold = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  // monitor: pop on every result strobe, otherwise results must hold the last expected value
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (bus.vld_out) begin
      if (sb.size() == 0) chk("spurious_vld", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quot", bus.quot_out, e.q);
        chk("rem", bus.rem_out, e.r);
        chk("div_zero", bus.div_zero, e.dz);
        chk("latency", cyc, e.due);
        if (e.d != 0) begin
          chk("invariant", 32'(bus.quot_out) * 32'(e.d) + 32'(bus.rem_out), 32'(e.n));
          chk("rem_lt_d", bus.rem_out < e.d, 1);
        end
        hold = {e.q, e.r, e.dz};
      end
    end else chk("held", {bus.quot_out, bus.rem_out, bus.div_zero}, hold);
  end
  task automatic drive(input logic [2*W-1:0] n, input logic [W-1:0] d, input bit push);
    exp_t e;
    bus.vld_in = 1'b1;
    bus.N = n;
    bus.D = d;
    if (push) begin
      e.n = n;
      e.d = d;
      e.q = (d == 0) ? '1 : n / 16'(d);
      e.r = (d == 0) ? '0 : W'(n % 16'(d));
      e.dz = d == 0;
      e.due = cyc + 1 + 2*W;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.vld_in = 1'b0;
    bus.N = 16'($urandom);
    bus.D = 8'($urandom);
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask
  logic [2*W-1:0] tn[7] = '{216, 1000, 65535, 5, 0, 100, 100};
  logic [W-1:0]   td[7] = '{6, 7, 255, 9, 3, 0, 10};
  initial begin
    int trial;
    bus.vld_in = 1'b0;
    bus.N = '0;
    bus.D = '0;
    for (int i = 0; i < 200; i++) begin
      s_div = 8'($urandom_range(255, 1));
      s_rem = 8'($urandom_range(int'(s_div) - 1, 0));
      s_bit = 1'($urandom);
      #1;
      trial = int'(s_rem) * 2 + int'(s_bit);
      chk("step", {s_orem, s_q}, trial >= int'(s_div) ? {W'(trial - int'(s_div)), 1'b1} : {W'(trial), 1'b0});
    end
    @(negedge clk);
    chk("rst_outputs", {bus.busy, bus.vld_out, bus.quot_out, bus.rem_out, bus.div_zero}, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tn[i], td[i], 1);
      chk("busy_run", bus.busy, 1);
      wait_empty();
      chk("busy_idle", bus.busy, 0);
    end
    @(negedge clk);
    drive(50, 5, 1);
    repeat (3) @(negedge clk);
    chk("busy_ignore", bus.busy, 1);
    drive(9, 3, 0);
    for (int i = 0; i < 40 && !bus.vld_out; i++) @(negedge clk);
    chk("done_seen", bus.vld_out, 1);
    drive(9, 3, 1);
    wait_empty();
    repeat (20) @(negedge clk);
    drive(300, 7, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    hold = '0;
    #1;
    chk("rst_async", {bus.busy, bus.vld_out, bus.quot_out, bus.rem_out, bus.div_zero}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    drive(300, 7, 1);
    wait_empty();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      drive((i % 4 == 0) ? 16'($urandom_range(600, 0)) : 16'($urandom), 8'($urandom_range(255, 1)), 1);
      wait_empty();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
